// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, opcode/register constants and next-PC select encoding
package pipeline_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_BEQ = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JAL = 4'h8;
  localparam logic [3:0] OP_RET = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [2:0] REG_ZERO = 3'd0;
  localparam logic [2:0] REG_SP   = 3'd6;
  localparam logic [2:0] REG_LR   = 3'd7;
  localparam logic [INST_W-1:0] NOP_INST = {OP_NOP, 12'h000};
  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_BRANCH,
    PC_JUMP,
    PC_RET,
    PC_RESET
  } pc_sel_e;
  function automatic logic is_redirect(input pc_sel_e s);
    return (s == PC_BRANCH) || (s == PC_JUMP) || (s == PC_RET);
  endfunction
endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address stack that overwrites its oldest entry when full
module return_address_stack
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] wr_idx;
  logic [CW-1:0] cnt;
  assign full   = cnt == CW'(DEPTH);
  assign empty  = cnt == '0;
  assign top    = empty ? '0 : mem[ptr];
  assign wr_idx = pop ? ptr : ptr + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + 1'b1;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop && !push && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, next-PC priority mux and wrong-path kill toward instruction memory
module fetch_pc_unit
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic [ADDR_W-1:0] link_addr,
  input  logic              ret,
  output logic [ADDR_W-1:0] address,
  output logic              stall,
  output logic              kill,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  pc_sel_e sel;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ras_top;
  logic push;
  logic pop;
  logic ras_full;
  logic ras_empty;
  always_comb begin
    sel = reset        ? PC_RESET  :
          branch_taken ? PC_BRANCH :
          jump         ? PC_JUMP   :
          ret          ? PC_RET    :
          stall_in     ? PC_HOLD   : PC_SEQ;
  end
  assign push = (sel == PC_JUMP) && call;
  assign pop  = ret && ((sel == PC_RET) || push);
  return_address_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(link_addr),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );
  always_comb begin
    next_pc = (sel == PC_RESET)  ? RESET_PC      :
              (sel == PC_BRANCH) ? branch_target :
              (sel == PC_JUMP)   ? jump_target   :
              (sel == PC_RET)    ? ras_top       :
              (sel == PC_HOLD)   ? pc            : pc_plus1;
  end
  assign address  = pc;
  assign pc_plus1 = pc + 1'b1;
  assign stall    = stall_in && (sel == PC_HOLD);
  always_ff @(posedge clk) begin
    pc   <= next_pc;
    kill <= is_redirect(sel);
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= ras_overflow | (push && !pop && ras_full);
      ras_underflow <= ras_underflow | (pop && ras_empty);
    end
  end
endmodule
